// File: rtl/mcs4_rom_responder.sv
// rtl/mcs4_rom_responder.sv - MCS-4 style ROM chip bus responder with I/O port
module mcs4_rom_responder #(
  parameter logic [3:0] CHIP_ID = 4'h0
) (
  input  logic       sysclk,
  input  logic       poc,
  input  logic       clk2,
  input  logic       sync,
  input  logic       cmrom,
  input  logic [3:0] data_in,
  output logic [3:0] data_out,
  output logic       data_oe,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_data,
  input  logic [3:0] io_in,
  output logic [3:0] io_out,
  output logic [2:0] phase,
  output logic       idle
);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_A1,
    ST_A2,
    ST_A3,
    ST_M1,
    ST_M2,
    ST_X1,
    ST_X2,
    ST_X3
  } state_t;

  localparam logic [3:0] OPR_IO  = 4'hE;
  localparam logic [3:0] OPA_WRR = 4'h2;
  localparam logic [3:0] OPA_RDR = 4'hA;

  state_t     state;
  state_t     state_nxt;
  logic       clk2_q;
  logic       boundary;
  logic       entering_a1;
  logic [7:0] addr;
  logic       sel;
  logic [3:0] opr;
  logic [3:0] opa;
  logic       io_cmd;
  logic       src_sel;
  logic       rdr_active;

  // A subcycle ends where clk2 falls, as seen through one sysclk register.
  assign boundary    = clk2_q & ~clk2;
  assign entering_a1 = boundary & sync;
  assign rom_addr    = addr;
  assign rdr_active  = io_cmd & src_sel & (opa == OPA_RDR);

  // Delay clk2 by one sysclk so its falling edge can be detected.
  always_ff @(posedge sysclk) begin
    if (poc) begin
      clk2_q <= 1'b0;
    end else begin
      clk2_q <= clk2;
    end
  end

  // Sequencer state register; advances only at subcycle boundaries.
  always_ff @(posedge sysclk) begin
    if (poc) begin
      state <= ST_IDLE;
    end else if (boundary) begin
      state <= state_nxt;
    end
  end

  // Next subcycle: sync forces A1 from anywhere, missing sync after X3 drops to idle.
  always_comb begin
    state_nxt = state;
    if (sync) begin
      state_nxt = ST_A1;
    end else begin
      case (state)
        ST_IDLE: state_nxt = ST_IDLE;
        ST_A1:   state_nxt = ST_A2;
        ST_A2:   state_nxt = ST_A3;
        ST_A3:   state_nxt = ST_M1;
        ST_M1:   state_nxt = ST_M2;
        ST_M2:   state_nxt = ST_X1;
        ST_X1:   state_nxt = ST_X2;
        ST_X2:   state_nxt = ST_X3;
        ST_X3:   state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Bus drive and status decode from registered state only.
  always_comb begin
    data_oe  = 1'b0;
    data_out = 4'h0;
    phase    = 3'd0;
    idle     = 1'b0;
    case (state)
      ST_IDLE: idle  = 1'b1;
      ST_A1:   phase = 3'd0;
      ST_A2:   phase = 3'd1;
      ST_A3:   phase = 3'd2;
      ST_M1: begin
        phase = 3'd3;
        if (sel) begin
          data_oe  = 1'b1;
          data_out = rom_data[7:4];
        end
      end
      ST_M2: begin
        phase = 3'd4;
        if (sel) begin
          data_oe  = 1'b1;
          data_out = rom_data[3:0];
        end
      end
      ST_X1:   phase = 3'd5;
      ST_X2: begin
        phase = 3'd6;
        if (rdr_active) begin
          data_oe  = 1'b1;
          data_out = io_in;
        end
      end
      ST_X3:   phase = 3'd7;
      default: idle  = 1'b1;
    endcase
  end

  // Bus latches: each captures data_in as its subcycle ends; entering A1 wins over a capture.
  always_ff @(posedge sysclk) begin
    if (poc) begin
      addr    <= 8'h00;
      sel     <= 1'b0;
      opr     <= 4'h0;
      opa     <= 4'h0;
      io_cmd  <= 1'b0;
      src_sel <= 1'b0;
      io_out  <= 4'h0;
    end else if (boundary) begin
      case (state)
        ST_A1: addr[3:0] <= data_in;
        ST_A2: addr[7:4] <= data_in;
        ST_A3: sel       <= cmrom & (data_in == CHIP_ID);
        ST_M1: opr       <= data_in;
        ST_M2: begin
          opa    <= data_in;
          io_cmd <= cmrom & (opr == OPR_IO);
        end
        ST_X2: begin
          // SRC (chip select for later I/O) and WRR are mutually exclusive via io_cmd.
          if (cmrom && !io_cmd) begin
            src_sel <= (data_in == CHIP_ID);
          end
          if (io_cmd && src_sel && (opa == OPA_WRR)) begin
            io_out <= data_in;
          end
        end
        default: ;
      endcase
      if (entering_a1) begin
        sel    <= 1'b0;
        io_cmd <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mcs4_rom_responder.sv
// tb/tb_mcs4_rom_responder.sv - scoreboard bench for mcs4_rom_responder
module tb_mcs4_rom_responder;

  localparam logic [3:0] CHIP = 4'h3;

  typedef struct packed {
    logic       oe;
    logic [3:0] dout;
    logic [2:0] ph;
    logic       idl;
  } obs_t;

  logic       sysclk;
  logic       poc;
  logic       clk2;
  logic       sync;
  logic       cmrom;
  logic [3:0] data_in;
  logic [3:0] data_out;
  logic       data_oe;
  logic [7:0] rom_addr;
  logic [7:0] rom_data;
  logic [3:0] io_in;
  logic [3:0] io_out;
  logic [2:0] phase;
  logic       idle;

  int checks;
  int failures;
  obs_t exp_q[$];
  logic src_sel_m;
  logic [3:0] io_out_m;

  mcs4_rom_responder #(.CHIP_ID(CHIP)) dut (
    .sysclk  (sysclk),
    .poc     (poc),
    .clk2    (clk2),
    .sync    (sync),
    .cmrom   (cmrom),
    .data_in (data_in),
    .data_out(data_out),
    .data_oe (data_oe),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .io_in   (io_in),
    .io_out  (io_out),
    .phase   (phase),
    .idle    (idle)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  // ROM array model: contents are addr ^ 8'h72, one sysclk read latency.
  always @(posedge sysclk) rom_data <= rom_addr ^ 8'h72;

  // One subcycle: clk2 high for two sysclks then low for two; outputs sampled mid-subcycle.
  task automatic sub(input logic [3:0] d, input logic s, input logic cm, output obs_t o);
    @(negedge sysclk);
    data_in = d;
    sync    = s;
    cmrom   = cm;
    clk2    = 1'b1;
    @(negedge sysclk);
    o.oe   = data_oe;
    o.dout = data_out;
    o.ph   = phase;
    o.idl  = idle;
    @(negedge sysclk);
    clk2 = 1'b0;
    @(negedge sysclk);
  endtask

  // Drives subcycles 0..sync_idx (sync on the last one; sync_idx>7 means a full instruction without sync).
  task automatic run_instr(input string name, input logic live,
                           input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] a3,
                           input logic [3:0] m1, input logic [3:0] m2, input logic [3:0] x2,
                           input logic cm_a3, input logic cm_m2, input logic cm_x2,
                           input int sync_idx);
    logic [7:0] addr;
    logic [7:0] rom;
    logic       sel;
    logic       iocmd;
    logic [3:0] d;
    logic       cm;
    obs_t       e;
    obs_t       o;
    int         last;
    addr  = {a2, a1};
    rom   = addr ^ 8'h72;
    sel   = cm_a3 && (a3 == CHIP);
    iocmd = cm_m2 && (m1 == 4'hE);
    last  = (sync_idx > 7) ? 7 : sync_idx;
    for (int k = 0; k <= last; k++) begin
      e = '0;
      if (!live) begin
        e.idl = 1'b1;
      end else begin
        e.ph = k[2:0];
        if (k == 3 && sel) begin e.oe = 1'b1; e.dout = rom[7:4]; end
        if (k == 4 && sel) begin e.oe = 1'b1; e.dout = rom[3:0]; end
        if (k == 6 && iocmd && src_sel_m && m2 == 4'hA) begin e.oe = 1'b1; e.dout = io_in; end
      end
      exp_q.push_back(e);
    end
    for (int k = 0; k <= last; k++) begin
      case (k)
        0: begin d = a1; cm = 1'b0;  end
        1: begin d = a2; cm = 1'b0;  end
        2: begin d = a3; cm = cm_a3; end
        3: begin d = m1; cm = 1'b0;  end
        4: begin d = m2; cm = cm_m2; end
        6: begin d = x2; cm = cm_x2; end
        default: begin d = 4'h0; cm = 1'b0; end
      endcase
      sub(d, (k == sync_idx), cm, o);
      e = exp_q.pop_front();
      checks++;
      if ((o.oe !== e.oe) || (o.dout !== e.dout) || (o.idl !== e.idl) ||
          (!e.idl && (o.ph !== e.ph))) begin
        failures++;
        $display("FAIL %s sub%0d oe/out/phase/idle got %b/%h/%0d/%b want %b/%h/%0d/%b",
                 name, k, o.oe, o.dout, o.ph, o.idl, e.oe, e.dout, e.ph, e.idl);
      end
      if (live && k == 3) begin
        checks++;
        if (rom_addr !== addr) begin
          failures++;
          $display("FAIL %s rom_addr got %h want %h", name, rom_addr, addr);
        end
      end
    end
    if (live && last >= 6) begin
      if (cm_x2 && !iocmd) src_sel_m = (x2 == CHIP);
      else if (iocmd && src_sel_m && m2 == 4'h2) io_out_m = x2;
    end
    checks++;
    if (io_out !== io_out_m) begin
      failures++;
      $display("FAIL %s io_out got %h want %h", name, io_out, io_out_m);
    end
  endtask

  task automatic sync_pulse(input string name);
    obs_t o;
    sub(4'h0, 1'b1, 1'b0, o);
    checks++;
    if (o.oe !== 1'b0 || o.idl !== 1'b1) begin
      failures++;
      $display("FAIL %s idle-sync oe/idle got %b/%b want 0/1", name, o.oe, o.idl);
    end
  endtask

  task automatic test_reset();
    poc = 1'b1; clk2 = 1'b0; sync = 1'b0; cmrom = 1'b0;
    data_in = 4'h0; io_in = 4'h0;
    src_sel_m = 1'b0; io_out_m = 4'h0;
    repeat (3) @(negedge sysclk);
    checks++;
    if ({data_oe, data_out, rom_addr, idle, phase, io_out} !== {1'b0, 4'h0, 8'h00, 1'b1, 3'd0, 4'h0}) begin
      failures++;
      $display("FAIL reset oe/out/addr/idle/phase/io got %b/%h/%h/%b/%0d/%h want 0/0/00/1/0/0",
               data_oe, data_out, rom_addr, idle, phase, io_out);
    end
    poc = 1'b0;
    @(negedge sysclk);
  endtask

  task automatic test_fetch();
    sync_pulse("fetch");
    run_instr("fetch_sel", 1'b1, 4'h5, 4'hA, 4'h3, 4'h1, 4'h2, 4'h0, 1'b1, 1'b0, 1'b0, 7);
    run_instr("fetch_sel2", 1'b1, 4'hF, 4'h0, 4'h3, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 7);
  endtask

  task automatic test_not_selected();
    run_instr("nsel_chip", 1'b1, 4'h5, 4'hA, 4'h2, 4'h1, 4'h2, 4'h0, 1'b1, 1'b0, 1'b0, 7);
    run_instr("nsel_cm", 1'b1, 4'h5, 4'hA, 4'h3, 4'h1, 4'h2, 4'h0, 1'b0, 1'b0, 1'b0, 7);
  endtask

  task automatic test_src_wrr();
    run_instr("src3", 1'b1, 4'h0, 4'h0, 4'h0, 4'h2, 4'h1, 4'h3, 1'b0, 1'b0, 1'b1, 7);
    run_instr("wrr9", 1'b1, 4'h1, 4'h0, 4'h0, 4'hE, 4'h2, 4'h9, 1'b0, 1'b1, 1'b0, 7);
    run_instr("src4", 1'b1, 4'h2, 4'h0, 4'h0, 4'h2, 4'h1, 4'h4, 1'b0, 1'b0, 1'b1, 7);
    run_instr("wrr5_nsel", 1'b1, 4'h3, 4'h0, 4'h0, 4'hE, 4'h2, 4'h5, 1'b0, 1'b1, 1'b0, 7);
  endtask

  task automatic test_rdr();
    io_in = 4'hC;
    run_instr("src3b", 1'b1, 4'h0, 4'h0, 4'h0, 4'h2, 4'h1, 4'h3, 1'b0, 1'b0, 1'b1, 7);
    run_instr("rdr", 1'b1, 4'h1, 4'h0, 4'h0, 4'hE, 4'hA, 4'h0, 1'b0, 1'b1, 1'b0, 7);
    io_in = 4'h6;
    run_instr("rdr_nocm", 1'b1, 4'h1, 4'h0, 4'h0, 4'hE, 4'hA, 4'h0, 1'b0, 1'b0, 1'b0, 7);
  endtask

  task automatic test_sync_loss();
    run_instr("last_sync", 1'b1, 4'h5, 4'hA, 4'h3, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 8);
    run_instr("lost", 1'b0, 4'h5, 4'hA, 4'h3, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 8);
    sync_pulse("resync");
    run_instr("mid_sync", 1'b1, 4'h5, 4'hA, 4'h3, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 3);
    run_instr("after_mid", 1'b1, 4'h7, 4'h6, 4'h3, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 7);
  endtask

  task automatic test_poc_mid();
    obs_t o;
    sub(4'h5, 1'b0, 1'b0, o);
    sub(4'hA, 1'b0, 1'b0, o);
    sub(4'h3, 1'b0, 1'b1, o);
    @(negedge sysclk);
    data_in = 4'h0; cmrom = 1'b0; clk2 = 1'b1;
    @(negedge sysclk);
    checks++;
    if (data_oe !== 1'b1 || data_out !== 4'hD) begin
      failures++;
      $display("FAIL poc_pre oe/out got %b/%h want 1/d", data_oe, data_out);
    end
    poc = 1'b1;
    @(negedge sysclk);
    poc = 1'b0;
    src_sel_m = 1'b0; io_out_m = 4'h0;
    checks++;
    if ({data_oe, data_out, idle, io_out, rom_addr} !== {1'b0, 4'h0, 1'b1, 4'h0, 8'h00}) begin
      failures++;
      $display("FAIL poc_mid oe/out/idle/io/addr got %b/%h/%b/%h/%h want 0/0/1/0/00",
               data_oe, data_out, idle, io_out, rom_addr);
    end
    @(negedge sysclk);
    clk2 = 1'b0;
    @(negedge sysclk);
    checks++;
    if (idle !== 1'b1) begin
      failures++;
      $display("FAIL poc_boundary idle got %b want 1", idle);
    end
    run_instr("poc_idle", 1'b0, 4'h5, 4'hA, 4'h3, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 8);
    sync_pulse("poc_resync");
    io_in = 4'hB;
    run_instr("rdr_after_poc", 1'b1, 4'h1, 4'h0, 4'h0, 4'hE, 4'hA, 4'h0, 1'b0, 1'b1, 1'b0, 7);
    run_instr("fetch_after_poc", 1'b1, 4'h5, 4'hA, 4'h3, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 7);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_fetch();
    test_not_selected();
    test_src_wrr();
    test_rdr();
    test_sync_loss();
    test_src_wrr();
    test_poc_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
